// File: rtl/edge_scan_pkg.sv
// Shared types and default parameters for the multi-channel falling-edge scan controller.
package edge_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    REPORT = 2'd2
  } scan_state_t;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_GATE_CYCLES = 100;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/fall_edge_sync.sv
// Free-running 3-flop synchronizer with falling-edge detector for one asynchronous input.
module fall_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall
);

  logic s_p0, s_p1, s_p2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_p0 <= 1'b0;
      s_p1 <= 1'b0;
      s_p2 <= 1'b0;
    end else begin
      s_p0 <= din;
      s_p1 <= s_p0;
      s_p2 <= s_p1;
    end
  end

  assign fall = ~s_p1 & s_p2;

endmodule

// File: rtl/edge_scan_ctrl.sv
// Round-robin falling-edge counter scheduler: one shared saturating counter gated per channel.
// Define EDGE_SCAN_CONT_EN to rescan continuously until abort instead of stopping after one sweep.
module edge_scan_ctrl
  import edge_scan_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [N_CH-1:0]         signal_in,
  output logic                    busy,
  output logic [CNT_W-1:0]        result,
  output logic [$clog2(N_CH)-1:0] result_ch,
  output logic                    result_ovf,
  output logic                    result_valid,
  output logic                    done
);

  localparam int                CH_W     = $clog2(N_CH);
  localparam int                TMR_W    = $clog2(GATE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(N_CH - 1);
  localparam logic [TMR_W-1:0]  LAST_TMR = TMR_W'(GATE_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? v + 1'b1 : v;
  endfunction

  logic [N_CH-1:0] fall;

  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    fall_edge_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (signal_in[i]),
      .fall (fall[i])
    );
  end

  scan_state_t      state, state_nxt;
  logic [CH_W-1:0]  ch;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [TMR_W-1:0] tmr;
  logic             ovf, ovf_nxt;
  logic             pulse;

  assign pulse   = fall[ch];
  assign cnt_nxt = sat_inc(cnt, pulse);
  assign ovf_nxt = ovf | (pulse & (cnt == CNT_MAX));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && !abort) state_nxt = GATE;
      GATE: begin
        if (abort)                 state_nxt = IDLE;
        else if (tmr == LAST_TMR)  state_nxt = REPORT;
      end
      REPORT: begin
        if (abort)                 state_nxt = IDLE;
        else if (ch != LAST_CH)    state_nxt = GATE;
        else begin
`ifdef EDGE_SCAN_CONT_EN
          state_nxt = GATE;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Results are captured on the edge that closes the gate, so they are visible during REPORT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ch           <= '0;
      cnt          <= '0;
      tmr          <= '0;
      ovf          <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_ch    <= '0;
      result_ovf   <= 1'b0;
      result_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      busy         <= (state_nxt != IDLE);
      result_valid <= 1'b0;
      done         <= 1'b0;
      unique case (state)
        GATE: begin
          cnt <= cnt_nxt;
          ovf <= ovf_nxt;
          tmr <= tmr + 1'b1;
          if (!abort && (tmr == LAST_TMR)) begin
            result       <= cnt_nxt;
            result_ch    <= ch;
            result_ovf   <= ovf_nxt;
            result_valid <= 1'b1;
            done         <= (ch == LAST_CH);
          end
        end
        REPORT: begin
          cnt <= '0;
          tmr <= '0;
          ovf <= 1'b0;
          ch  <= (ch == LAST_CH) ? '0 : ch + 1'b1;
        end
        default: begin
          cnt <= '0;
          tmr <= '0;
          ovf <= 1'b0;
          ch  <= '0;
        end
      endcase
    end
  end

endmodule
